// File: rtl/syscall_monitor.sv
// Syscall monitor: watches retired register state for print/exit syscalls and buffers
// header/data records in a first-word-fall-through FIFO. Optional timestamps: SYSMON_TIMESTAMP_EN.
module syscall_monitor #(
  parameter int DATA_W     = 32,
  parameter int NREG       = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CODE_REG   = 2,
  parameter int DATA_REG   = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREG*DATA_W-1:0] reg_bus,
  input  logic                   retire,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_hdr,
  output logic [DATA_W-1:0]      out_data,
  output logic [31:0]            out_ts,
  output logic                   halt,
  output logic                   done,
  output logic                   overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, STREAM, HALTED} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   last_dat_q, last_dat_d;
  logic                last_vld_q, last_vld_d;
  logic                overflow_q, overflow_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W:0]     rec_mem [FIFO_DEPTH];

  logic [DATA_W-1:0]   code, dat;
  logic                push, push_hdr, push_ok, pop, empty, full;
  logic                unused_bus;

  assign code       = reg_bus[DATA_W*CODE_REG +: DATA_W];
  assign dat        = reg_bus[DATA_W*DATA_REG +: DATA_W];
  assign unused_bus = ^reg_bus;

  always_comb begin
    state_d    = state_q;
    last_dat_d = last_dat_q;
    last_vld_d = last_vld_q;
    push       = 1'b0;
    push_hdr   = 1'b0;
    if (retire) begin
      case (state_q)
        IDLE: begin
          if (code == DATA_W'(1)) begin
            push       = 1'b1;
            push_hdr   = 1'b1;
            last_vld_d = 1'b0;
            state_d    = STREAM;
          end else if (code == DATA_W'(3)) begin
            state_d = HALTED;
          end
        end
        STREAM: begin
          if (code == DATA_W'(1)) begin
            push       = 1'b1;
            push_hdr   = 1'b1;
            last_vld_d = 1'b0;
          end else if (code == DATA_W'(2)) begin
            // Only value changes are recorded; the first sample after a header always is.
            if (!last_vld_q || dat != last_dat_q) begin
              push       = 1'b1;
              last_dat_d = dat;
              last_vld_d = 1'b1;
            end
          end else if (code == DATA_W'(3)) begin
            state_d = HALTED;
          end
        end
        default: ;
      endcase
    end
  end

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign pop        = !empty && out_ready;
  assign push_ok    = push && (!full || pop);
  assign overflow_d = overflow_q | (push && full && !pop);
  assign count_d    = count_q + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_dat_q <= '0;
      last_vld_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_dat_q <= last_dat_d;
      last_vld_q <= last_vld_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) rec_mem[wr_ptr_q] <= {push_hdr, (push_hdr ? {DATA_W{1'b0}} : dat)};
  end

  // Head fields are masked while empty so nothing stale leaks out after reset.
  assign out_valid = !empty;
  assign out_hdr   = empty ? 1'b0 : rec_mem[rd_ptr_q][DATA_W];
  assign out_data  = empty ? '0 : rec_mem[rd_ptr_q][DATA_W-1:0];
  assign halt      = (state_q == HALTED);
  assign done      = (state_q == HALTED) && empty;
  assign overflow  = overflow_q;

`ifdef SYSMON_TIMESTAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] ts_mem [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_q <= '0;
    else      cyc_q <= cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) ts_mem[wr_ptr_q] <= cyc_q;
  end

  assign out_ts = empty ? 32'd0 : ts_mem[rd_ptr_q];
`else
  assign out_ts = 32'd0;
`endif

endmodule

// File: tb/tb_syscall_monitor.sv
// Randomized + directed bench for syscall_monitor against a queue-based record model.
module tb_syscall_monitor;
  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int DEPTH = 8;
`ifdef SYSMON_TIMESTAMP_EN
  localparam logic [31:0] EXP_TS9 = 32'd9;
`else
  localparam logic [31:0] EXP_TS9 = 32'd0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NR*DW-1:0]   reg_bus = '0;
  logic               retire = 1'b0;
  logic               out_valid, out_ready = 1'b0, out_hdr;
  logic [DW-1:0]      out_data;
  logic [31:0]        out_ts;
  logic               halt, done, overflow;

  syscall_monitor #(.DATA_W(DW), .NREG(NR), .FIFO_DEPTH(DEPTH), .CODE_REG(2), .DATA_REG(20)) dut (
    .clk(clk), .rst(rst), .reg_bus(reg_bus), .retire(retire),
    .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr),
    .out_data(out_data), .out_ts(out_ts), .halt(halt), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {bit hdr; logic [31:0] data; logic [31:0] ts;} rec_t;

  rec_t        mq[$];
  rec_t        got[$];
  bit          m_stream, m_halted, m_last_v, m_ovf;
  logic [31:0] m_last;
  logic [31:0] m_cyc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_stream = 0; m_halted = 0; m_last_v = 0; m_ovf = 0; m_last = '0; m_cyc = '0;
  endfunction

  // One rising edge worth of behaviour, derived from the record rules.
  function automatic void model_edge(bit ret, logic [31:0] code, logic [31:0] dat, bit rdy);
    bit   pop = (mq.size() > 0) && rdy;
    bit   push = 0;
    rec_t r;
`ifdef SYSMON_TIMESTAMP_EN
    r.ts = m_cyc;
`else
    r.ts = 32'd0;
`endif
    r.hdr = 0; r.data = '0;
    if (ret && !m_halted) begin
      if (code == 32'd3) m_halted = 1;
      else if (code == 32'd1) begin
        push = 1; r.hdr = 1; m_stream = 1; m_last_v = 0;
      end else if (code == 32'd2 && m_stream && (!m_last_v || dat != m_last)) begin
        push = 1; r.data = dat; m_last = dat; m_last_v = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ovf = 1;
    end
    m_cyc = m_cyc + 32'd1;
  endfunction

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_hdr", 64'(out_hdr), 64'(mq[0].hdr));
      chk("out_data", 64'(out_data), 64'(mq[0].data));
      chk("out_ts", 64'(out_ts), 64'(mq[0].ts));
    end
    chk("halt", 64'(halt), 64'(m_halted));
    chk("done", 64'(done), 64'(m_halted && mq.size() == 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  // Called at a falling edge: drive inputs, advance model, clock once, compare.
  task automatic step(input bit ret, input logic [31:0] code, input logic [31:0] dat, input bit rdy);
    rec_t r;
    for (int k = 0; k < NR; k++) reg_bus[k*DW +: DW] = $urandom();
    reg_bus[2*DW +: DW]  = code;
    reg_bus[20*DW +: DW] = dat;
    retire    = ret;
    out_ready = rdy;
    if (out_valid && rdy) begin
      r.hdr = out_hdr; r.data = out_data; r.ts = out_ts;
      got.push_back(r);
      $display("rec hdr=%0d data=0x%08h ts=%0d", out_hdr, out_data, out_ts);
    end
    model_edge(ret, code, dat, rdy);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    retire = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ts", 64'(out_ts), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    check_all();
  endtask

  initial begin
    int rdy_pct;
    model_reset();
    @(negedge clk);
    chk("init_valid", 64'(out_valid), 64'd0);
    chk("init_hdr", 64'(out_hdr), 64'd0);
    chk("init_data", 64'(out_data), 64'd0);
    chk("init_ts", 64'(out_ts), 64'd0);
    chk("init_halt", 64'(halt), 64'd0);
    chk("init_done", 64'(done), 64'd0);
    chk("init_ovf", 64'(overflow), 64'd0);
    rst = 1'b1;

    // Header on the 10th edge after reset, then the print-change sequence.
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("ts10_valid", 64'(out_valid), 64'd1);
    chk("ts10_ts", 64'(out_ts), 64'(EXP_TS9));
    got.delete();
    step(1, 2, 5, 1);
    step(1, 2, 9, 1);
    step(1, 2, 9, 1);
    step(1, 2, 32'hFFFF_FFFD, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("seq_len", 64'(got.size()), 64'd4);
    chk("seq0_hdr", 64'(got[0].hdr), 64'd1);
    chk("seq0_ts", 64'(got[0].ts), 64'(EXP_TS9));
    chk("seq1", 64'(got[1].data), 64'd5);
    chk("seq2", 64'(got[2].data), 64'd9);
    chk("seq3", 64'(got[3].data), 64'hFFFF_FFFD);

    // Overflow: header + 8 data with no consumer.
    async_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 2, 100 + i, 0);
    chk("ovf_set", 64'(overflow), 64'd1);
    got.delete();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    chk("ovf_len", 64'(got.size()), 64'd8);
    chk("ovf_hdr", 64'(got[0].hdr), 64'd1);
    for (int k = 1; k < 8; k++) chk("ovf_data", 64'(got[k].data), 64'(100 + k - 1));

    // Full FIFO with simultaneous pop and push.
    async_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 2, 200 + i, 0);
    step(1, 2, 300, 1);
    chk("full_ovf", 64'(overflow), 64'd0);
    step(0, 0, 0, 0);
    got.delete();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    chk("full_len", 64'(got.size()), 64'd8);
    chk("full_last", 64'(got[7].data), 64'd300);
    chk("full_first", 64'(got[0].data), 64'd200);

    // Exit with three pending records.
    async_reset();
    step(1, 1, 0, 0);
    step(1, 2, 7, 0);
    step(1, 2, 8, 0);
    step(1, 3, 0, 0);
    chk("halt_set", 64'(halt), 64'd1);
    chk("halt_done0", 64'(done), 64'd0);
    step(0, 0, 0, 1);
    chk("done_1pop", 64'(done), 64'd0);
    step(0, 0, 0, 1);
    chk("done_2pop", 64'(done), 64'd0);
    step(0, 0, 0, 1);
    chk("done_3pop", 64'(done), 64'd1);
    step(1, 1, 0, 1);
    chk("halted_ignore", 64'(out_valid), 64'd0);

    // Mid-stream reset with four pending.
    async_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 2, 40 + i, 0);
    chk("pend4", 64'(out_valid), 64'd1);
    async_reset();
    step(1, 2, 50, 1);
    step(1, 2, 51, 1);
    chk("post_rst_quiet", 64'(out_valid), 64'd0);
    step(1, 1, 0, 0);
    chk("post_rst_hdr", 64'(out_hdr), 64'd1);

    // Randomized traffic.
    rdy_pct = 90;
    for (int n = 0; n < 1500; n++) begin
      int pick;
      logic [31:0] code;
      if (n % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: rdy_pct = 15;
          1: rdy_pct = 50;
          default: rdy_pct = 90;
        endcase
      end
      pick = int'($urandom_range(0, 39));
      if (pick < 26)      code = 32'd2;
      else if (pick < 32) code = 32'd1;
      else if (pick == 39) code = 32'd3;
      else                code = (pick < 36) ? 32'd0 : 32'd4 + $urandom_range(0, 7);
      step(1'($urandom_range(0, 1)), code, 32'($urandom_range(0, 3)),
           $urandom_range(0, 99) < rdy_pct);
      if ((m_halted && mq.size() == 0) || $urandom_range(0, 299) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
